// File: rtl/segasys1_hiscore_engine.sv
// Hiscore transfer engine: pauses the video block and copies a contiguous block of
// video RAM into a byte buffer (save) or back out of it (load). The host has its own buffer port.
module segasys1_hiscore_engine #(
  parameter int MAX_LEN = 256,
  parameter int AW      = 8,
  parameter int SETTLE  = 4
) (
  input  logic          VCLKx8,
  input  logic          RESET,
  input  logic          save_req,
  input  logic          load_req,
  input  logic [15:0]   cfg_base,
  input  logic [AW:0]   cfg_len,
  output logic          busy,
  output logic          done,
  output logic          HS_PAUSE_N,
  output logic [15:0]   HSAD,
  output logic [7:0]    HSDI,
  output logic          HSWE,
  input  logic [7:0]    HSDO,
  input  logic [AW-1:0] host_ad,
  input  logic [7:0]    host_din,
  input  logic          host_we,
  output logic [7:0]    host_dout
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0] MAX_LEN_W = (AW + 1)'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE, PAUSE, S_ADR, S_CAP, L_FET, L_WR, REL, DONE
  } state_t;

  state_t        state_q, state_d;
  logic          is_load_q, is_load_d;
  logic [15:0]   base_q, base_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   hsad_q, hsad_d;
  logic [7:0]    hsdi_q;
  logic [7:0]    host_dout_q;
  logic [7:0]    mem [MAX_LEN];

  logic [AW:0]   len_clamp;
  logic [AW:0]   idx_nxt;
  logic          last;

  assign len_clamp = (cfg_len > MAX_LEN_W) ? MAX_LEN_W : cfg_len;
  assign idx_nxt   = idx_q + 1'b1;
  assign last      = (idx_q == len_q - 1'b1);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d   = state_q;
    is_load_d = is_load_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    hsad_d    = hsad_q;
    case (state_q)
      IDLE: begin
        if (save_req || load_req) begin
          // A simultaneous save wins; the load is dropped.
          is_load_d = !save_req;
          base_d    = cfg_base;
          len_d     = len_clamp;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = (len_clamp == '0) ? DONE : PAUSE;
        end
      end
      PAUSE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          if (is_load_q) begin
            state_d = L_FET;
          end else begin
            state_d = S_ADR;
            hsad_d  = base_q + 16'(idx_q);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ADR: state_d = S_CAP;
      S_CAP: begin
        if (last) begin
          state_d = REL;
        end else begin
          idx_d   = idx_nxt;
          hsad_d  = base_q + 16'(idx_nxt);
          state_d = S_ADR;
        end
      end
      L_FET: begin
        state_d = L_WR;
        hsad_d  = base_q + 16'(idx_q);
      end
      L_WR: begin
        if (last) begin
          state_d = REL;
        end else begin
          idx_d   = idx_nxt;
          state_d = L_FET;
        end
      end
      REL:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge VCLKx8 or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      hsad_q      <= '0;
      hsdi_q      <= '0;
      host_dout_q <= '0;
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      hsad_q      <= hsad_d;
      host_dout_q <= mem[host_ad];
      // Fetch during L_FET so the byte is on HSDI for the whole L_WR cycle.
      if (state_q == L_FET) hsdi_q <= mem[idx_q[AW-1:0]];
    end
  end

  // NOTE: the buffer array has no reset; its contents are only meaningful once written.
  always_ff @(posedge VCLKx8) begin
    if (state_q == S_CAP) begin
      mem[idx_q[AW-1:0]] <= HSDO;
    end else if (host_we && !busy) begin
      mem[host_ad] <= host_din;
    end
  end

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign HS_PAUSE_N = !busy;
  assign done       = (state_q == DONE);
  assign HSWE       = (state_q == L_WR);
  assign HSAD       = hsad_q;
  assign HSDI       = hsdi_q;
  assign host_dout  = host_dout_q;

endmodule

// File: tb/tb_segasys1_hiscore_engine.sv
// Directed bench for segasys1_hiscore_engine: a registered-read video RAM model on the
// hiscore port, a scoreboard of expected bus writes and buffer bytes, and timed checks.
module tb_segasys1_hiscore_engine;
  localparam int MAX_LEN = 256;
  localparam int AW      = 8;
  localparam int SETTLE  = 4;

  logic          VCLKx8 = 1'b0;
  logic          RESET = 1'b1;
  logic          save_req = 1'b0, load_req = 1'b0;
  logic [15:0]   cfg_base = '0;
  logic [AW:0]   cfg_len = '0;
  logic          busy, done, HS_PAUSE_N, HSWE;
  logic [15:0]   HSAD;
  logic [7:0]    HSDI;
  logic [7:0]    HSDO;
  logic [AW-1:0] host_ad = '0;
  logic [7:0]    host_din = '0;
  logic          host_we = 1'b0;
  logic [7:0]    host_dout;

  logic          cpu_we = 1'b0;
  logic [15:0]   cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic [7:0]    vram [65536];

  int n_checks = 0, n_err = 0, cur = 0;
  int hswe_cnt = 0, done_cnt = 0, pause_cnt = 0;
  logic [23:0] bus_q[$];
  logic [7:0]  byte_q[$];

  segasys1_hiscore_engine #(.MAX_LEN(MAX_LEN), .AW(AW), .SETTLE(SETTLE)) dut (
    .VCLKx8(VCLKx8), .RESET(RESET), .save_req(save_req), .load_req(load_req),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .busy(busy), .done(done),
    .HS_PAUSE_N(HS_PAUSE_N), .HSAD(HSAD), .HSDI(HSDI), .HSWE(HSWE), .HSDO(HSDO),
    .host_ad(host_ad), .host_din(host_din), .host_we(host_we), .host_dout(host_dout)
  );

  always #5 VCLKx8 = ~VCLKx8;

  // Video RAM: registered read, write on HSWE, CPU port for preload.
  always @(posedge VCLKx8) begin
    if (HSWE) vram[HSAD] <= HSDI;
    else if (cpu_we) vram[cpu_addr] <= cpu_wdata;
    HSDO <= vram[HSAD];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge VCLKx8) begin
    logic [23:0] e;
    if (!RESET) begin
      if (done) done_cnt++;
      if (!HS_PAUSE_N) pause_cnt++;
      if (HSWE) begin
        hswe_cnt++;
        e = (bus_q.size() > 0) ? bus_q.pop_front() : 24'hxxxxxx;
        check("hswe_bus", {8'h00, HSAD, HSDI}, {8'h00, e});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge VCLKx8);
      #1;
    end
  endtask

  task automatic to_edge(input int k);
    cyc(k - cur);
    cur = k;
  endtask

  task automatic start_req(input logic s, input logic l, input logic [15:0] b,
                           input logic [AW:0] n);
    cfg_base = b;
    cfg_len  = n;
    save_req = s;
    load_req = l;
    cyc(1);
    save_req = 1'b0;
    load_req = 1'b0;
    cur = 1;
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (!done && k < limit) begin
      cyc(1);
      k++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [7:0] d);
    host_ad  = a;
    host_din = d;
    host_we  = 1'b1;
    cyc(1);
    host_we  = 1'b0;
  endtask

  task automatic host_rd(input string tag, input logic [AW-1:0] a);
    logic [7:0] e;
    host_ad = a;
    cyc(1);
    e = (byte_q.size() > 0) ? byte_q.pop_front() : 8'hxx;
    check(tag, {24'd0, host_dout}, {24'd0, e});
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    cyc(1);
    cpu_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, p0, d0;
    logic [7:0] ld [4];
    ld[0] = 8'hA5; ld[1] = 8'h5A; ld[2] = 8'hC3; ld[3] = 8'h3C;

    cyc(1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pause_n", {31'd0, HS_PAUSE_N}, 32'd1);
    check("rst_hswe", {31'd0, HSWE}, 32'd0);
    check("rst_hsad", {16'd0, HSAD}, 32'h0);
    check("rst_hsdi", {24'd0, HSDI}, 32'h0);
    check("rst_host_dout", {24'd0, host_dout}, 32'h0);
    cyc(1);
    RESET = 1'b0;
    cyc(1);

    for (int j = 0; j < 16; j++) cpu_wr(16'hE000 + 16'(j), 8'h10 + 8'(j));
    cpu_wr(16'hE020, 8'h42);
    cpu_wr(16'hE021, 8'h43);
    cpu_wr(16'hE0FF, 8'h77);
    for (int j = 0; j < 4; j++) cpu_wr(16'hF000 + 16'(j), 8'h55);
    cyc(1);

    // Save 16 bytes from VRAM0
    h0 = hswe_cnt;
    start_req(1'b1, 1'b0, 16'hE000, 9'd16);
    check("save_busy", {31'd0, busy}, 32'd1);
    check("save_pause_n", {31'd0, HS_PAUSE_N}, 32'd0);
    for (int j = 0; j < 16; j++) begin
      to_edge(5 + 2 * j);
      check("save_hsad", {16'd0, HSAD}, 32'hE000 + 32'(j));
      to_edge(6 + 2 * j);
      check("save_hsad_hold", {16'd0, HSAD}, 32'hE000 + 32'(j));
    end
    to_edge(37);
    check("save_rel_done", {31'd0, done}, 32'd0);
    check("save_rel_pause_n", {31'd0, HS_PAUSE_N}, 32'd0);
    to_edge(38);
    check("save_done", {31'd0, done}, 32'd1);
    check("save_done_pause_n", {31'd0, HS_PAUSE_N}, 32'd1);
    check("save_done_busy", {31'd0, busy}, 32'd0);
    to_edge(39);
    check("save_done_pulse", {31'd0, done}, 32'd0);
    check("save_no_hswe", hswe_cnt - h0, 32'd0);
    for (int j = 0; j < 16; j++) begin
      byte_q.push_back(8'h10 + 8'(j));
      host_rd("save_buf", AW'(j));
    end

    // Load 4 bytes to sprite RAM
    for (int j = 0; j < 4; j++) begin
      host_wr(AW'(j), ld[j]);
      bus_q.push_back({16'hD100 + 16'(j), ld[j]});
    end
    h0 = hswe_cnt;
    p0 = pause_cnt;
    start_req(1'b0, 1'b1, 16'hD100, 9'd4);
    wait_done(100);
    cyc(1);
    check("load_hswe_count", hswe_cnt - h0, 32'd4);
    check("load_pause_len", pause_cnt - p0, 32'(SETTLE + 9));
    check("load_bus_drained", bus_q.size(), 32'd0);
    for (int j = 0; j < 4; j++)
      check("load_cpu_readback", {24'd0, vram[16'hD100 + 16'(j)]}, {24'd0, ld[j]});

    // Zero length
    p0 = pause_cnt;
    d0 = done_cnt;
    start_req(1'b1, 1'b0, 16'hE000, 9'd0);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_busy", {31'd0, busy}, 32'd0);
    check("len0_pause_n", {31'd0, HS_PAUSE_N}, 32'd1);
    cyc(2);
    check("len0_no_pause", pause_cnt - p0, 32'd0);
    check("len0_one_done", done_cnt - d0, 32'd1);

    // Length clamp: 300 -> 256
    start_req(1'b1, 1'b0, 16'hE000, 9'd300);
    to_edge(SETTLE + 2 * MAX_LEN + 1);
    check("clamp_not_done", {31'd0, done}, 32'd0);
    to_edge(SETTLE + 2 * MAX_LEN + 2);
    check("clamp_done", {31'd0, done}, 32'd1);
    cyc(1);
    byte_q.push_back(8'h77);
    host_rd("clamp_buf255", AW'(255));

    // Address wrap
    start_req(1'b1, 1'b0, 16'hFFFE, 9'd4);
    to_edge(5);  check("wrap_hsad0", {16'd0, HSAD}, 32'hFFFE);
    to_edge(7);  check("wrap_hsad1", {16'd0, HSAD}, 32'hFFFF);
    to_edge(9);  check("wrap_hsad2", {16'd0, HSAD}, 32'h0000);
    to_edge(11); check("wrap_hsad3", {16'd0, HSAD}, 32'h0001);
    wait_done(50);
    cyc(1);

    // Simultaneous requests, load during busy, host write during busy
    host_wr(AW'(200), 8'h11);
    h0 = hswe_cnt;
    d0 = done_cnt;
    start_req(1'b1, 1'b1, 16'hE020, 9'd2);
    host_ad  = AW'(200);
    host_din = 8'hEE;
    host_we  = 1'b1;
    to_edge(2);
    host_we  = 1'b0;
    load_req = 1'b1;
    to_edge(3);
    load_req = 1'b0;
    wait_done(50);
    cyc(8);
    check("both_no_hswe", hswe_cnt - h0, 32'd0);
    check("busy_load_ignored", done_cnt - d0, 32'd1);
    byte_q.push_back(8'h11);
    host_rd("busy_host_wr_dropped", AW'(200));
    byte_q.push_back(8'h42);
    host_rd("both_save_buf0", AW'(0));
    byte_q.push_back(8'h43);
    host_rd("both_save_buf1", AW'(1));
    host_wr(AW'(200), 8'hEE);
    byte_q.push_back(8'hEE);
    host_rd("idle_host_wr", AW'(200));

    // Reset mid-load after two bytes
    for (int j = 0; j < 4; j++) host_wr(AW'(j), 8'h01 + 8'(j));
    bus_q.push_back({16'hF000, 8'h01});
    bus_q.push_back({16'hF001, 8'h02});
    start_req(1'b0, 1'b1, 16'hF000, 9'd4);
    to_edge(9);
    RESET = 1'b1;
    #1;
    check("rst_mid_hswe", {31'd0, HSWE}, 32'd0);
    check("rst_mid_pause_n", {31'd0, HS_PAUSE_N}, 32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hsad", {16'd0, HSAD}, 32'h0);
    cyc(1);
    RESET = 1'b0;
    cyc(1);
    check("rst_mid_vram0", {24'd0, vram[16'hF000]}, 32'h01);
    check("rst_mid_vram1", {24'd0, vram[16'hF001]}, 32'h02);
    check("rst_mid_vram2", {24'd0, vram[16'hF002]}, 32'h55);
    check("rst_mid_vram3", {24'd0, vram[16'hF003]}, 32'h55);
    check("rst_mid_bus_drained", bus_q.size(), 32'd0);

    // Save after reset
    start_req(1'b1, 1'b0, 16'hE000, 9'd4);
    wait_done(50);
    cyc(1);
    for (int j = 0; j < 4; j++) begin
      byte_q.push_back(8'h10 + 8'(j));
      host_rd("post_rst_save_buf", AW'(j));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
